// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Fetch-stage program-counter generator. Issues instruction fetch requests
//   over a valid/ready handshake and advances the PC by STEP on every accepted
//   request. Trap and branch redirects replace the sequential PC. A trap
//   always wins over a branch. A redirect that arrives while a request is
//   stalled is held in a one-entry pending buffer, so it is never lost.
//   Branch targets are checked for alignment. A misaligned branch is dropped
//   and reported one cycle later.
//
// Ports:
//   i_clk               clock, rising edge
//   i_rst               synchronous active-high reset
//   i_en                fetch enable (no new request launched when 0)
//   i_br_valid          branch/jump redirect pulse
//   i_br_target         branch/jump target
//   i_trap_valid        trap redirect pulse
//   i_trap_target       trap vector (low ALIGN_BITS forced to zero)
//   i_req_ready         instruction memory accepts the request this cycle
//   o_req_valid         fetch request valid
//   o_pc                fetch address (current PC)
//   o_pc_next           PC value after the next rising edge (combinational)
//   o_req_stale         the current request is wrong-path; discard its data
//   o_redirect_pending  a buffered redirect waits for the current accept
//   o_misalign          one-cycle pulse: branch target failed alignment
//   o_misalign_addr     offending branch target while o_misalign=1
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned              XLEN         = 32,
  parameter logic [XLEN-1:0]          RESET_VECTOR = '0,
  parameter int unsigned              STEP         = 4,
  parameter int unsigned              ALIGN_BITS   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_target,
  input  logic            i_req_ready,
  output logic            o_req_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_req_stale,
  output logic            o_redirect_pending,
  output logic            o_misalign,
  output logic [XLEN-1:0] o_misalign_addr
);

  // Low-order bits that must be zero in any instruction address.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [XLEN-1:0] STEP_W     = XLEN'(STEP);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            pend_trap_q, pend_trap_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic            accept_s;
  logic            br_misaligned_s;
  logic            br_aligned_s;
  logic            redir_s;
  logic [XLEN-1:0] trap_target_s;
  logic [XLEN-1:0] redir_target_s;

  // Redirect qualification: traps are silently aligned, misaligned branches are dropped.
  always_comb begin
    accept_s        = valid_q & i_req_ready;
    trap_target_s   = i_trap_target & ~ALIGN_MASK;
    br_misaligned_s = i_br_valid & ((i_br_target & ALIGN_MASK) != '0);
    br_aligned_s    = i_br_valid & ~br_misaligned_s;
    redir_s         = i_trap_valid | br_aligned_s;
    if (i_trap_valid) begin
      redir_target_s = trap_target_s;
    end else begin
      redir_target_s = i_br_target;
    end
  end

  // Next PC and pending-redirect buffer, in priority order.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_trap_d   = pend_trap_q;
    if (redir_s && (!valid_q || accept_s)) begin
      // Redirect can take effect immediately: no request is stuck in flight.
      pc_d          = redir_target_s;
      pend_valid_d  = 1'b0;
      pend_target_d = '0;
      pend_trap_d   = 1'b0;
    end else if (redir_s) begin
      // Request is stalled: keep presenting it, remember where to go next.
      // A buffered trap must not be displaced by a later branch.
      pend_valid_d = 1'b1;
      if (i_trap_valid) begin
        pend_target_d = trap_target_s;
        pend_trap_d   = 1'b1;
      end else if (!pend_valid_q || !pend_trap_q) begin
        pend_target_d = i_br_target;
        pend_trap_d   = 1'b0;
      end else begin
        pend_target_d = pend_target_q;
        pend_trap_d   = pend_trap_q;
      end
    end else if (accept_s && pend_valid_q) begin
      pc_d          = pend_target_q;
      pend_valid_d  = 1'b0;
      pend_target_d = '0;
      pend_trap_d   = 1'b0;
    end else if (accept_s) begin
      pc_d = pc_q + STEP_W;
    end else begin
      pc_d = pc_q;
    end
  end

  // Request valid and misalignment report.
  always_comb begin
    // A presented request is held until accepted, even if fetch is disabled.
    if (valid_q && !i_req_ready) begin
      valid_d = 1'b1;
    end else begin
      valid_d = i_en;
    end
    misalign_d = br_misaligned_s;
    if (br_misaligned_s) begin
      misalign_addr_d = i_br_target;
    end else begin
      misalign_addr_d = misalign_addr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q            <= RESET_VECTOR;
      valid_q         <= 1'b0;
      pend_valid_q    <= 1'b0;
      pend_target_q   <= '0;
      pend_trap_q     <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      pc_q            <= pc_d;
      valid_q         <= valid_d;
      pend_valid_q    <= pend_valid_d;
      pend_target_q   <= pend_target_d;
      pend_trap_q     <= pend_trap_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign o_req_valid        = valid_q;
  assign o_pc               = pc_q;
  assign o_pc_next          = pc_d;
  assign o_req_stale        = valid_q & (pend_valid_q | redir_s);
  assign o_redirect_pending = pend_valid_q;
  assign o_misalign         = misalign_q;
  assign o_misalign_addr    = misalign_addr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_br_valid;
  logic [31:0] i_br_target;
  logic        i_trap_valid;
  logic [31:0] i_trap_target;
  logic        i_req_ready;

  logic        o_req_valid, o_req_stale, o_redirect_pending, o_misalign;
  logic [31:0] o_pc, o_pc_next, o_misalign_addr;

  logic        a1_req_valid, a1_req_stale, a1_redirect_pending, a1_misalign;
  logic [31:0] a1_pc, a1_pc_next, a1_misalign_addr;

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  always #5 i_clk = ~i_clk;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .STEP(4), .ALIGN_BITS(2)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .i_br_valid(i_br_valid), .i_br_target(i_br_target),
    .i_trap_valid(i_trap_valid), .i_trap_target(i_trap_target),
    .i_req_ready(i_req_ready),
    .o_req_valid(o_req_valid), .o_pc(o_pc), .o_pc_next(o_pc_next),
    .o_req_stale(o_req_stale), .o_redirect_pending(o_redirect_pending),
    .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr)
  );

  // Second instance allowing compressed (2-byte aligned) targets, same stimulus.
  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .STEP(4), .ALIGN_BITS(1)) u_dut_a1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .i_br_valid(i_br_valid), .i_br_target(i_br_target),
    .i_trap_valid(i_trap_valid), .i_trap_target(i_trap_target),
    .i_req_ready(i_req_ready),
    .o_req_valid(a1_req_valid), .o_pc(a1_pc), .o_pc_next(a1_pc_next),
    .o_req_stale(a1_req_stale), .o_redirect_pending(a1_redirect_pending),
    .o_misalign(a1_misalign), .o_misalign_addr(a1_misalign_addr)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b0; i_br_valid = 1'b0; i_br_target = 32'h0;
    i_trap_valid = 1'b0; i_trap_target = 32'h0; i_req_ready = 1'b0;
    tick(); tick();
    n_vec++; if (o_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", o_req_valid); end
    n_vec++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=00000000", o_pc); end
    n_vec++; if (o_redirect_pending !== 1'b0 || o_misalign !== 1'b0 || o_misalign_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_flags pend=%0b mis=%0b addr=%h exp=0/0/0", o_redirect_pending, o_misalign, o_misalign_addr); end
    i_rst = 1'b0; i_en = 1'b1; i_req_ready = 1'b1;
    tick();
    n_vec++; if (o_req_valid !== 1'b1 || o_pc !== 32'h0) begin
      n_fail++; $display("FAIL first_req valid=%0b pc=%h exp=1/00000000", o_req_valid, o_pc); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      exp_v = exp_q.pop_front();
      n_vec++; if (o_pc !== exp_v || o_req_valid !== 1'b1) begin
        n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h valid=%0b", i, o_pc, exp_v, o_req_valid); end
      tick();
    end
  endtask

  task automatic test_stall();
    i_req_ready = 1'b0; i_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (o_req_valid !== 1'b1 || o_pc !== 32'h10) begin
        n_fail++; $display("FAIL stall_hold[%0d] valid=%0b pc=%h exp=1/00000010", i, o_req_valid, o_pc); end
    end
    i_req_ready = 1'b1;
    #1;
    n_vec++; if (o_pc_next !== 32'h14) begin n_fail++; $display("FAIL stall_pc_next got=%h exp=00000014", o_pc_next); end
    tick();
    n_vec++; if (o_pc !== 32'h14 || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_release pc=%h valid=%0b exp=00000014/0", o_pc, o_req_valid); end
    i_en = 1'b1;
    tick();
  endtask

  task automatic test_branch_pending();
    i_trap_valid = 1'b1; i_trap_target = 32'h20;
    exp_q.push_back(32'h20);
    tick();
    i_trap_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_vec++; if (o_pc !== exp_v) begin n_fail++; $display("FAIL trap_redirect got=%h exp=%h", o_pc, exp_v); end
    i_req_ready = 1'b0; i_br_valid = 1'b1; i_br_target = 32'h100;
    #1;
    n_vec++; if (o_req_stale !== 1'b1 || o_pc_next !== 32'h20) begin
      n_fail++; $display("FAIL br_stall_comb stale=%0b pc_next=%h exp=1/00000020", o_req_stale, o_pc_next); end
    tick();
    i_br_valid = 1'b0;
    #1;
    n_vec++; if (o_redirect_pending !== 1'b1 || o_req_stale !== 1'b1 || o_pc !== 32'h20) begin
      n_fail++; $display("FAIL br_pending pend=%0b stale=%0b pc=%h exp=1/1/00000020", o_redirect_pending, o_req_stale, o_pc); end
    i_req_ready = 1'b1;
    exp_q.push_back(32'h100);
    tick();
    exp_v = exp_q.pop_front();
    n_vec++; if (o_pc !== exp_v || o_redirect_pending !== 1'b0 || o_req_stale !== 1'b0) begin
      n_fail++; $display("FAIL br_release pc=%h exp=%h pend=%0b stale=%0b", o_pc, exp_v, o_redirect_pending, o_req_stale); end
  endtask

  task automatic test_trap_priority_pending();
    i_req_ready = 1'b0; i_trap_valid = 1'b1; i_trap_target = 32'h80;
    tick();
    i_trap_valid = 1'b0; i_br_valid = 1'b1; i_br_target = 32'h200;
    tick();
    i_br_valid = 1'b0;
    n_vec++; if (o_redirect_pending !== 1'b1 || o_pc !== 32'h100) begin
      n_fail++; $display("FAIL trap_pend pend=%0b pc=%h exp=1/00000100", o_redirect_pending, o_pc); end
    i_req_ready = 1'b1;
    exp_q.push_back(32'h80);
    tick();
    exp_v = exp_q.pop_front();
    n_vec++; if (o_pc !== exp_v || o_redirect_pending !== 1'b0) begin
      n_fail++; $display("FAIL trap_retained pc=%h exp=%h pend=%0b", o_pc, exp_v, o_redirect_pending); end
  endtask

  task automatic test_same_cycle();
    i_trap_valid = 1'b1; i_trap_target = 32'h83;  // low bits forced to zero
    i_br_valid = 1'b1; i_br_target = 32'h40;
    exp_q.push_back(32'h80);
    tick();
    i_trap_valid = 1'b0; i_br_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_vec++; if (o_pc !== exp_v || o_misalign !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle pc=%h exp=%h misalign=%0b", o_pc, exp_v, o_misalign); end
  endtask

  task automatic test_misalign();
    i_br_valid = 1'b1; i_br_target = 32'h102;
    exp_q.push_back(32'h84);
    exp_q.push_back(32'h88);
    tick();
    i_br_valid = 1'b0;
    exp_v = exp_q.pop_front();
    n_vec++; if (o_pc !== exp_v) begin n_fail++; $display("FAIL mis_pc got=%h exp=%h", o_pc, exp_v); end
    n_vec++; if (o_misalign !== 1'b1 || o_misalign_addr !== 32'h102) begin
      n_fail++; $display("FAIL mis_flag mis=%0b addr=%h exp=1/00000102", o_misalign, o_misalign_addr); end
    n_vec++; if (a1_pc !== 32'h102 || a1_misalign !== 1'b0) begin
      n_fail++; $display("FAIL a1_accept pc=%h mis=%0b exp=00000102/0", a1_pc, a1_misalign); end
    tick();
    exp_v = exp_q.pop_front();
    n_vec++; if (o_pc !== exp_v || o_misalign !== 1'b0) begin
      n_fail++; $display("FAIL mis_pulse pc=%h exp=%h mis=%0b", o_pc, exp_v, o_misalign); end
  endtask

  task automatic test_wrap();
    i_trap_valid = 1'b1; i_trap_target = 32'hFFFF_FFFC;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    tick();
    i_trap_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_v = exp_q.pop_front();
      n_vec++; if (o_pc !== exp_v) begin n_fail++; $display("FAIL wrap[%0d] got=%h exp=%h", i, o_pc, exp_v); end
      if (i == 0) tick();
    end
  endtask

  task automatic test_reset_mid();
    i_req_ready = 1'b0; i_br_valid = 1'b1; i_br_target = 32'h300;
    tick();
    i_br_valid = 1'b0;
    n_vec++; if (o_redirect_pending !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup pend=%0b exp=1", o_redirect_pending); end
    i_rst = 1'b1;
    tick();
    n_vec++; if (o_pc !== 32'h0 || o_redirect_pending !== 1'b0 || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid pc=%h pend=%0b valid=%0b exp=00000000/0/0", o_pc, o_redirect_pending, o_req_valid); end
    i_rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_pending();
    test_trap_priority_pending();
    test_same_cycle();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout after 100000 time units");
    $fatal(1);
  end

endmodule
